// File: rtl/b9_misr_pkg.sv
// Shared widths, FSM state encoding and default feedback polynomial for the b9 response MISR.
package b9_misr_pkg;

    localparam int unsigned B9_OUT_W = 21;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } b9_state_e;

    // x^21 + x^2 + 1, taps below bit 21
    localparam logic [B9_OUT_W-1:0] B9_POLY_DEF = 21'h000005;

endpackage

// File: rtl/b9_resp_misr_if.sv
// Valid/ready stream carrying b9 response vectors into the MISR.
interface b9_resp_misr_if;
    import b9_misr_pkg::*;

    logic                in_valid;
    logic [B9_OUT_W-1:0] in_data;
    logic                in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/b9_misr_core.sv
// Single MISR register with seed load and per-beat shift/feedback/xor step.
module b9_misr_core
    import b9_misr_pkg::*;
#(
    parameter logic [B9_OUT_W-1:0] SEED = '0,
    parameter logic [B9_OUT_W-1:0] POLY = B9_POLY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_en,
    input  logic [B9_OUT_W-1:0] i_data,
    output logic [B9_OUT_W-1:0] o_sig
);

    logic [B9_OUT_W-1:0] r_sig;
    logic [B9_OUT_W-1:0] w_step;

    always_comb begin
        w_step = {r_sig[B9_OUT_W-2:0], 1'b0}
               ^ (r_sig[B9_OUT_W-1] ? POLY : '0)
               ^ i_data;
    end

    // load wins over a beat; the FSM never asserts both together anyway
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= '0;
        end else if (i_load) begin
            r_sig <= SEED;
        end else if (i_en) begin
            r_sig <= w_step;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/b9_resp_misr.sv
// Run-controlled MISR compactor for b9 response vectors.
// Optional signature compare (i_golden/o_pass) enabled by defining B9_MISR_CMP_EN.
module b9_resp_misr
    import b9_misr_pkg::*;
#(
    parameter logic [B9_OUT_W-1:0] SEED = 21'h000000,
    parameter logic [B9_OUT_W-1:0] POLY = B9_POLY_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [CNT_W-1:0]     i_cnt_target,
    b9_resp_misr_if.slave        bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [B9_OUT_W-1:0]  o_signature,
    output logic [CNT_W-1:0]     o_vec_count
`ifdef B9_MISR_CMP_EN
   ,input  logic [B9_OUT_W-1:0]  i_golden
   ,output logic                 o_pass
`endif
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_RUN  = S_RUN;
    localparam logic [1:0] ST_DONE = S_DONE;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] w_target_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_beat;
    logic             w_start_acc;

    assign w_beat      = bus.in_valid && r_ready;
    assign w_start_acc = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // next-state, counter and target; ready is precomputed so it is a pure register
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt  = ST_RUN;
                    w_count_nxt  = '0;
                    w_target_nxt = i_cnt_target;
                end
            end
            ST_RUN: begin
                if (w_beat) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end
                if (r_count == r_target) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == ST_RUN) && (w_count_nxt != w_target_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    b9_misr_core #(
        .SEED (SEED),
        .POLY (POLY)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_start_acc),
        .i_en   (w_beat),
        .i_data (bus.in_data),
        .o_sig  (o_signature)
    );

    assign bus.in_ready = r_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_vec_count  = r_count;

`ifdef B9_MISR_CMP_EN
    logic r_pass;

    // valid from the second DONE cycle on; cleared as soon as a restart leaves DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else begin
            r_pass <= (r_state == ST_DONE) && (w_state_nxt == ST_DONE)
                   && (o_signature == i_golden);
        end
    end

    assign o_pass = r_pass;
`endif

endmodule

// File: tb/tb_b9_resp_misr.sv
// Self-checking bench for b9_resp_misr against a polynomial-arithmetic reference model.
module tb_b9_resp_misr;
    import b9_misr_pkg::*;

    localparam logic [20:0] M_SEED  = 21'h000000;
    localparam int unsigned M_POLY  = 32'h0000_0005;
    localparam int          CYC_MAX = 400;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [15:0] i_cnt_target;
    logic        o_busy;
    logic        o_done;
    logic [20:0] o_signature;
    logic [15:0] o_vec_count;
    logic [20:0] golden;
    logic        pass;

    int n_tests;
    int n_fail;

    bit          vld_q[$];
    logic [20:0] dat_q[$];
    logic [20:0] last_sig;

    b9_resp_misr_if bus ();

    b9_resp_misr dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_cnt_target (i_cnt_target),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_signature  (o_signature),
        .o_vec_count  (o_vec_count)
`ifdef B9_MISR_CMP_EN
       ,.i_golden     (golden)
       ,.o_pass       (pass)
`endif
    );

`ifndef B9_MISR_CMP_EN
    assign pass = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // multiply by x modulo x^21+x^2+1, then add the vector
    function automatic logic [20:0] mstep(input logic [20:0] s, input logic [20:0] d);
        int unsigned t;
        t = 32'(s) * 2;
        if (t >= 32'h0020_0000) t = t ^ (32'h0020_0000 | M_POLY);
        return 21'(t) ^ d;
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, ":ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, ":busy"},  32'(o_busy),       32'd0);
        chk({tag, ":done"},  32'(o_done),       32'd0);
        chk({tag, ":sig"},   32'(o_signature),  32'd0);
        chk({tag, ":cnt"},   32'(o_vec_count),  32'd0);
        chk({tag, ":pass"},  32'(pass),         32'd0);
    endtask

    // One full run: start, feed beats (queued or random), check RUN cycle by cycle, then DONE hold.
    task automatic run_seq(input string tag, input logic [15:0] tgt, input int mid_start);
        logic [20:0] msig;
        logic [20:0] d;
        int          taken;
        int          cyc;
        bit          vld;
        bit          exp_rdy;
        msig  = M_SEED;
        taken = 0;
        cyc   = 0;
        i_start      = 1'b1;
        i_cnt_target = tgt;
        tick();
        i_start      = 1'b0;
        i_cnt_target = 16'($urandom);
        chk({tag, ":start_busy"}, 32'(o_busy), 32'd1);
        chk({tag, ":start_done"}, 32'(o_done), 32'd0);
        while (1) begin
            exp_rdy = (taken != int'(tgt));
            chk({tag, ":run_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
            chk({tag, ":run_cnt"},   32'(o_vec_count),  32'(taken));
            chk({tag, ":run_sig"},   32'(o_signature),  32'(msig));
            chk({tag, ":run_busy"},  32'(o_busy),       32'd1);
            if (!exp_rdy) break;
            assert (cyc < CYC_MAX) else begin
                n_fail++;
                $error("FAIL %s:timeout observed %0d cycles expected below %0d", tag, cyc, CYC_MAX);
                break;
            end
            vld = (vld_q.size() > 0) ? vld_q.pop_front() : bit'($urandom_range(0, 1));
            d   = (dat_q.size() > 0) ? dat_q.pop_front() : 21'($urandom);
            bus.in_valid = vld;
            bus.in_data  = d;
            i_start      = (cyc == mid_start);
            tick();
            i_start = 1'b0;
            if (vld) begin
                taken++;
                msig = mstep(msig, d);
            end
            cyc++;
        end
        bus.in_valid = 1'($urandom);
        bus.in_data  = 21'($urandom);
        tick();
        chk({tag, ":done"},       32'(o_done),       32'd1);
        chk({tag, ":done_busy"},  32'(o_busy),       32'd0);
        chk({tag, ":done_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, ":done_cnt"},   32'(o_vec_count),  32'(tgt));
        chk({tag, ":done_sig"},   32'(o_signature),  32'(msig));
`ifdef B9_MISR_CMP_EN
        chk({tag, ":pass_entry"}, 32'(pass), 32'd0);
`endif
        bus.in_valid = 1'b1;
        bus.in_data  = 21'($urandom);
        tick();
        chk({tag, ":hold_done"}, 32'(o_done),      32'd1);
        chk({tag, ":hold_sig"},  32'(o_signature), 32'(msig));
        chk({tag, ":hold_cnt"},  32'(o_vec_count), 32'(tgt));
`ifdef B9_MISR_CMP_EN
        chk({tag, ":pass"}, 32'(pass), 32'(golden == msig));
`endif
        bus.in_valid = 1'b0;
        last_sig = msig;
    endtask

    initial begin
        logic [20:0] rv [4];
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_cnt_target = '0;
        golden       = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
        tick();
        chk_idle_zero("reset");
        rst = 1'b0;
        tick();
        chk_idle_zero("idle");

        // two basic signature vectors from seed 0
        golden = 21'h000005;
        vld_q = '{1'b1, 1'b1};
        dat_q = '{21'h100000, 21'h000000};
        run_seq("t37", 16'd2, -1);
        chk("t37:sig_const", 32'(o_signature), 32'h000005);
`ifdef B9_MISR_CMP_EN
        chk("t42:pass_hi", 32'(pass), 32'd1);
        golden = 21'h000004;
        vld_q = '{1'b1, 1'b1};
        dat_q = '{21'h100000, 21'h000000};
        run_seq("t42b", 16'd2, -1);
        chk("t42:pass_lo", 32'(pass), 32'd0);
`endif

        vld_q = '{1'b1, 1'b1};
        dat_q = '{21'h000001, 21'h000000};
        run_seq("t38", 16'd2, -1);
        chk("t38:sig_const", 32'(o_signature), 32'h000002);

        // zero target: one RUN cycle, nothing taken, seed out
        run_seq("t39", 16'd0, -1);
        chk("t39:sig_seed", 32'(o_signature), 32'(M_SEED));

        // gapped valid with an ignored start in the middle
        vld_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        run_seq("t40", 16'd3, 2);

        // reset after one of four beats, then a clean rerun of the same data
        for (int i = 0; i < 4; i++) rv[i] = 21'($urandom);
        i_start      = 1'b1;
        i_cnt_target = 16'd4;
        tick();
        i_start      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = rv[0];
        tick();
        rst          = 1'b1;
        bus.in_data  = rv[1];
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk_idle_zero("t41:rst");
        tick();
        chk_idle_zero("t41:after");
        vld_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) dat_q.push_back(rv[i]);
        run_seq("t41:rerun", 16'd4, -1);

        // reset beats a simultaneous start
        rst          = 1'b1;
        i_start      = 1'b1;
        i_cnt_target = 16'd5;
        tick();
        rst     = 1'b0;
        i_start = 1'b0;
        chk_idle_zero("rst_vs_start");

        // randomized runs with random gaps and random mid-run starts
        for (int k = 0; k < 8; k++) begin
            golden = ($urandom_range(0, 1) == 1) ? last_sig : 21'($urandom);
            run_seq($sformatf("rnd%0d", k), 16'($urandom_range(1, 14)), $urandom_range(0, 6));
        end

        // sustained back-to-back beats
        for (int i = 0; i < 10; i++) vld_q.push_back(1'b1);
        run_seq("b2b", 16'd10, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
